uart_tx_arbiter: RTL and testbench

- Shares the single UART byte transmitter (`vld_tx`/`rdy_tx`/`d_tx` byte interface) between N independent byte sources.
- Each source sends messages: byte streams terminated by a `last` flag.
- Grants one source at a time using round-robin, and holds the grant until that source's last byte is accepted. Messages from different sources never interleave on `txd`.
- A stalled granted source is released after a programmable idle timeout.
- Sits between the command/debug producers and the transmitter, in the same clock domain.

---
 rtl/uart_tx_arb_pkg.sv | 12 +
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default sizing for the UART transmitter arbiter.
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int N_SRC       = 4;
  localparam int ARB_TIMEOUT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-one search: lowest request index at or above ptr, modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] pick_id,
  output logic           pick_any
);

  logic [2*N-1:0] dbl;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  // Rotating the doubled vector puts the request at ptr into bit 0.
  always_comb begin
    dbl      = {req, req} >> ptr;
    off      = '0;
    pick_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        off      = IDW'(k);
        pick_any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(N)) begin
      sum = sum - (IDW+1)'(N);
    end
    pick_id = sum[IDW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among N message sources; a grant is held
// until the message's last byte is accepted or the source goes idle too long.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N       = N_SRC,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int IDW     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     src_vld,
  input  logic [N-1:0]     src_last,
  input  logic [8*N-1:0]   src_data,
  output logic [N-1:0]     src_rdy,
  output logic             vld_tx,
  output logic [7:0]       d_tx,
  input  logic             rdy_tx,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic             timeout_pulse
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           gnt_valid_nxt;
  logic           pulse_nxt;
  logic [CW-1:0]  idle_cnt, idle_cnt_nxt;

  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           sel_vld;
  logic           sel_last;
  logic           xfer;
  logic [IDW-1:0] ptr_inc;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req      (src_vld),
    .ptr      (ptr),
    .pick_id  (pick_id),
    .pick_any (pick_any)
  );

  assign sel_vld  = src_vld[gnt_id];
  assign sel_last = src_last[gnt_id];
  assign d_tx     = src_data[{gnt_id, 3'b000} +: 8];
  assign xfer     = (state == BUSY) && sel_vld && rdy_tx;
  // Explicit wrap keeps non-power-of-two source counts correct.
  assign ptr_inc  = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    pulse_nxt     = 1'b0;
    idle_cnt_nxt  = idle_cnt;
    vld_tx        = 1'b0;
    src_rdy       = '0;
    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (pick_any) begin
          gnt_id_nxt    = pick_id;
          gnt_valid_nxt = 1'b1;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        vld_tx          = sel_vld;
        src_rdy[gnt_id] = rdy_tx;
        if (xfer) begin
          idle_cnt_nxt = '0;
          if (sel_last) begin
            state_nxt     = IDLE;
            gnt_valid_nxt = 1'b0;
            ptr_nxt       = ptr_inc;
          end
        end else if (!sel_vld && (TIMEOUT != 0)) begin
          // Revoke one cycle early so the pulse lands exactly TIMEOUT cycles
          // after valid dropped; back-pressure (valid high) only holds the count.
          if (idle_cnt == CW'(TIMEOUT - 1)) begin
            state_nxt     = IDLE;
            gnt_valid_nxt = 1'b0;
            ptr_nxt       = ptr_inc;
            pulse_nxt     = 1'b1;
            idle_cnt_nxt  = '0;
          end else begin
            idle_cnt_nxt = idle_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_id        <= '0;
      gnt_valid     <= 1'b0;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      gnt_id        <= gnt_id_nxt;
      gnt_valid     <= gnt_valid_nxt;
      timeout_pulse <= pulse_nxt;
      idle_cnt      <= idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed messages per source, expected
// byte order queued up front, a negedge monitor pops on every accepted byte.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   src_vld, src_last, src_rdy;
  logic [8*N-1:0] src_data;
  logic           vld_tx, rdy_tx, gnt_valid, timeout_pulse;
  logic [7:0]     d_tx;
  logic [1:0]     gnt_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .src_vld       (src_vld),
    .src_last      (src_last),
    .src_data      (src_data),
    .src_rdy       (src_rdy),
    .vld_tx        (vld_tx),
    .d_tx          (d_tx),
    .rdy_tx        (rdy_tx),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id),
    .timeout_pulse (timeout_pulse)
  );

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];
  int to_seen = 0;
  bit chk_idle = 0;

  logic [7:0] m_data [N][16];
  bit         m_last [N][16];
  int         m_gap  [N][16];
  int         m_len  [N];
  int         m_pos  [N];
  int         m_wt   [N];
  bit         acc    [N];
  bit         tx_acc = 0;
  int         hold = 0;
  int         hold_len = 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_x(logic [1:0] id, logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic clear_src(int i);
    m_len[i] = 0;
    m_pos[i] = 0;
    m_wt[i]  = 0;
    acc[i]   = 0;
  endtask

  task automatic add_byte(int i, logic [7:0] d, bit l, int g);
    if (m_pos[i] == m_len[i]) m_wt[i] = g;
    m_data[i][m_len[i]] = d;
    m_last[i][m_len[i]] = l;
    m_gap[i][m_len[i]]  = g;
    m_len[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_pos[i] < 16) ? m_pos[i] : 0;
      src_vld[i]         = (m_pos[i] < m_len[i]) && (m_wt[i] == 0);
      src_last[i]        = m_last[i][k];
      src_data[8*i +: 8] = src_vld[i] ? m_data[i][k] : 8'h00;
    end
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (m_pos[i] < m_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Inputs change 1ns after the rising edge; handshakes are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_acc) hold = hold_len;
    else if (hold > 0) hold--;
    rdy_tx = (hold == 0);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_pos[i]++;
        if (m_pos[i] < m_len[i]) m_wt[i] = m_gap[i][m_pos[i]];
      end else if (m_wt[i] > 0) begin
        m_wt[i]--;
      end
    end
    drive();
    @(negedge clk);
    tx_acc = vld_tx && rdy_tx;
    for (int i = 0; i < N; i++) acc[i] = src_vld[i] && src_rdy[i];
  endtask

  task automatic run(string name, int budget);
    int n;
    n = 0;
    while (!(drained() && !gnt_valid && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_done: busy after %0d cycles, %0d bytes outstanding, required 0", name, n, exp_q.size());
    end
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    for (int i = 0; i < N; i++) clear_src(i);
    hold   = 0;
    rdy_tx = 1'b1;
    tx_acc = 0;
    drive();
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    to_seen = 0;
  endtask

  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (!rstn) begin
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("idle_after_last", gnt_valid, 0);
        chk_idle = 0;
      end
      if (timeout_pulse) to_seen++;
      if (vld_tx && rdy_tx) begin
        check("src_rdy_onehot", src_rdy, 4'b0001 << gnt_id);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got src %0d byte %0h, expected none", gnt_id, d_tx);
        end else begin
          e = exp_q.pop_front();
          check("xfer_src", gnt_id, e[9:8]);
          check("xfer_byte", d_tx, e[7:0]);
        end
        if (src_last[gnt_id]) chk_idle = 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn   = 1'b0;
    rdy_tx = 1'b1;
    for (int i = 0; i < N; i++) clear_src(i);
    src_vld  = '1;
    src_last = '1;
    src_data = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    check("rst_vld_tx", vld_tx, 0);
    check("rst_src_rdy", src_rdy, 0);
    check("rst_gnt_valid", gnt_valid, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    drive();
    #1 rstn = 1'b1;

    // Single source, 3-byte message
    add_byte(2, 8'h41, 0, 0);
    add_byte(2, 8'h42, 0, 0);
    add_byte(2, 8'h43, 1, 0);
    expect_x(2, 8'h41); expect_x(2, 8'h42); expect_x(2, 8'h43);
    tick();
    check("t1_not_yet_granted", gnt_valid, 0);
    tick();
    check("t1_gnt_valid", gnt_valid, 1);
    check("t1_gnt_id", gnt_id, 2);
    run("t1", 50);
    // ptr now 3: source 3 beats source 1
    add_byte(1, 8'h61, 1, 0);
    add_byte(3, 8'h63, 1, 0);
    expect_x(3, 8'h63); expect_x(1, 8'h61);
    run("t1_ptr", 50);

    // Contention from reset
    do_reset();
    add_byte(0, 8'h10, 0, 0); add_byte(0, 8'h11, 1, 0);
    add_byte(1, 8'h20, 0, 0); add_byte(1, 8'h21, 1, 0);
    expect_x(0, 8'h10); expect_x(0, 8'h11); expect_x(1, 8'h20); expect_x(1, 8'h21);
    run("t2", 60);

    // Round-robin fairness, 8 one-byte messages
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        add_byte(i, 8'h80 | 8'(i << 4) | 8'(m), 1, 0);
        expect_x(2'(i), 8'h80 | 8'(i << 4) | 8'(m));
      end
    run("t3", 120);

    // Timeout: source 1 stalls after a non-last byte, source 3 waits
    do_reset();
    add_byte(1, 8'h55, 0, 0);
    add_byte(3, 8'h77, 1, 0);
    expect_x(1, 8'h55); expect_x(3, 8'h77);
    n = 0;
    while (!acc[1] && n < 20) begin tick(); n++; end
    check("t4_src1_byte_seen", acc[1], 1);
    repeat (TO) tick();
    check("t4_no_early_pulse", timeout_pulse, 0);
    tick();
    check("t4_pulse", timeout_pulse, 1);
    check("t4_released", gnt_valid, 0);
    tick();
    check("t4_pulse_width", timeout_pulse, 0);
    check("t4_next_gnt_valid", gnt_valid, 1);
    check("t4_next_gnt_id", gnt_id, 3);
    run("t4", 50);
    check("t4_timeout_count", to_seen, 1);

    // Back-pressure longer than TIMEOUT never times out
    do_reset();
    hold_len = 25;
    add_byte(0, 8'hA0, 0, 0); add_byte(0, 8'hA1, 0, 0); add_byte(0, 8'hA2, 1, 0);
    expect_x(0, 8'hA0); expect_x(0, 8'hA1); expect_x(0, 8'hA2);
    run("t5", 200);
    check("t5_no_timeout", to_seen, 0);
    // Last byte arrives exactly when the idle count is at its terminal value
    hold_len = 1;
    add_byte(2, 8'hB0, 0, 0); add_byte(2, 8'hB1, 1, TO - 1);
    expect_x(2, 8'hB0); expect_x(2, 8'hB1);
    run("t5b", 100);
    check("t5b_no_timeout", to_seen, 0);

    // Reset mid-message (ptr is 3 here)
    hold_len = 3;
    add_byte(1, 8'hC0, 0, 0); add_byte(1, 8'hC1, 0, 0);
    add_byte(1, 8'hC2, 0, 0); add_byte(1, 8'hC3, 1, 0);
    expect_x(1, 8'hC0);
    n = 0;
    while (!acc[1] && n < 20) begin tick(); n++; end
    tick();
    check("t6_byte2_offered", vld_tx, 1);
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_vld_tx", vld_tx, 0);
    check("t6_rst_src_rdy", src_rdy, 0);
    check("t6_rst_gnt_valid", gnt_valid, 0);
    for (int i = 0; i < N; i++) clear_src(i);
    drive();
    repeat (2) tick();
    #1 rstn = 1'b1;
    add_byte(1, 8'hD1, 1, 0);
    add_byte(3, 8'hD3, 1, 0);
    expect_x(1, 8'hD1); expect_x(3, 8'hD3);
    run("t6", 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
